// File: rtl/blur_unnormalized_stencil_1_pe.sv
// 3x3 Gaussian blur compute stage: walks the output domain, issues tap/accumulator reads and
// writes acc + weighted 3x3 sum through a fixed 2-cycle pipeline.
module blur_unnormalized_stencil_1_pe #(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 62,
  parameter int unsigned IMG_H = 62
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            tap_ren,
  output logic [3*DW-1:0] tap_ctrl_vars,
  input  logic [9*DW-1:0] tap_data,
  output logic            acc_ren,
  output logic [3*DW-1:0] acc_ctrl_vars,
  input  logic [DW-1:0]   acc_data,
  output logic            res_wen,
  output logic [3*DW-1:0] res_ctrl_vars,
  output logic [DW-1:0]   res_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          r_state;
  logic [DW-1:0]   r_x;
  logic [DW-1:0]   r_y;
  logic            r_drain;
  logic            r_done;
  logic            r_s0_valid;
  logic [3*DW-1:0] r_s0_cv;
  logic            r_s1_valid;
  logic [3*DW-1:0] r_s1_cv;
  logic [DW-1:0]   r_s1_data;

  logic            w_run;
  logic            w_x_last;
  logic            w_y_last;
  logic [3*DW-1:0] w_cv;
  logic [DW-1:0]   w_t [9];
  logic [DW-1:0]   w_sum;

  assign w_run    = (r_state == StRun);
  assign w_x_last = (r_x == DW'(IMG_W - 1));
  assign w_y_last = (r_y == DW'(IMG_H - 1));
  assign w_cv     = {{DW{1'b0}}, r_y, r_x};

  for (genvar k = 0; k < 9; k++) begin : g_tap
    assign w_t[k] = tap_data[k*DW +: DW];
  end

  // Weights 1,2,1 / 2,4,2 / 1,2,1 as shifts; everything wraps at DW bits.
  assign w_sum = acc_data + w_t[0] + (w_t[1] << 1) + w_t[2] + (w_t[3] << 1) + (w_t[4] << 2)
               + (w_t[5] << 1) + w_t[6] + (w_t[7] << 1) + w_t[8];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_y        <= '0;
      r_drain    <= 1'b0;
      r_done     <= 1'b0;
      r_s0_valid <= 1'b0;
      r_s0_cv    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_cv    <= '0;
      r_s1_data  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s0_valid <= w_run && !flush;
      r_s1_valid <= r_s0_valid && !flush;
      if (w_run) begin
        r_s0_cv <= w_cv;
      end
      // Result registers hold between writes; only res_wen qualifies them.
      if (r_s0_valid && !flush) begin
        r_s1_cv   <= r_s0_cv;
        r_s1_data <= w_sum;
      end
      if (flush) begin
        r_state <= StIdle;
        r_x     <= '0;
        r_y     <= '0;
        r_drain <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start) begin
              r_state <= StRun;
              r_x     <= '0;
              r_y     <= '0;
            end
          end
          StRun: begin
            if (w_x_last) begin
              r_x <= '0;
              if (w_y_last) begin
                r_y     <= '0;
                r_drain <= 1'b0;
                r_state <= StDrain;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          StDrain: begin
            if (r_drain) begin
              r_drain <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_drain <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign busy          = (r_state != StIdle);
  assign done          = r_done;
  assign tap_ren       = w_run;
  assign tap_ctrl_vars = w_cv;
  assign acc_ren       = w_run;
  assign acc_ctrl_vars = w_cv;
  assign res_wen       = r_s1_valid;
  assign res_ctrl_vars = r_s1_cv;
  assign res_data      = r_s1_data;

endmodule

// File: doc/blur_unnormalized_stencil_1_pe.md
# blur_unnormalized_stencil_1_pe

Compute-and-sequencing stage for the 3x3 Gaussian blur. It sits between `hw_input_stencil_ub` (upstream, 9-tap read port) and `blur_unnormalized_stencil_clkwrk_dsa0_ub` / `blur_unnormalized_stencil_ub` (accumulator read, result write). It walks the 62x62 output domain, issues read control to both buffers, forms the weighted 3x3 sum plus the accumulator value, and writes one result per cycle through a fixed 2-cycle pipeline.

## Interface
- DW, 16, data and control-variable width
- IMG_W, 62, output columns (ctrl_vars[2] range 0..IMG_W-1)
- IMG_H, 62, output rows (ctrl_vars[1] range 0..IMG_H-1)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous reset, active-high (rst_n=1 resets), despite the suffix
- flush  in  1  synchronous abort to IDLE
- start  in  1  run request, sampled in IDLE only
- busy  out  1  high from first ren through last wen
- done  out  1  one-cycle pulse after the last wen
- tap_ren  out  1  read enable to the input stencil buffer
- tap_ctrl_vars  out  3xDW  {0, y, x} for the tap read
- tap_data  in  9xDW  taps, registered by the buffer, valid 1 cycle after tap_ren
- acc_ren  out  1  read enable to the accumulator buffer; equals tap_ren
- acc_ctrl_vars  out  3xDW  equals tap_ctrl_vars
- acc_data  in  DW  accumulator value, valid 1 cycle after acc_ren
- res_wen  out  1  write enable to the result buffer
- res_ctrl_vars  out  3xDW  tap_ctrl_vars delayed 2 cycles
- res_data  out  DW  result word

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 moves to RUN on the next edge and clears x and y to 0. In RUN, start is ignored.
- RUN: tap_ren=acc_ren=1 every cycle with ctrl_vars={0,y,x}. x increments each cycle. When x=IMG_W-1, x wraps to 0 and y increments. After issuing (IMG_H-1, IMG_W-1), move to DRAIN.
- DRAIN: lasts 2 cycles with no ren, then return to IDLE. done pulses in the first IDLE cycle.
- Tap k corresponds to offset (col=k%3, row=k/3) from (x,y).
- Weights: row-major 1,2,1 / 2,4,2 / 1,2,1.
- res_data = acc_data + t0 + 2t1 + t2 + 2t3 + 4t4 + 2t5 + t6 + 2t7 + t8, modulo 2^DW. Wrap silently; there is no saturation. Implement the shifts as left shifts truncated to DW.
- Pipeline:
  - Stage 0 registers ren and ctrl_vars alongside the buffer's own read register.
  - Stage 1 registers the sum, a valid bit, and the delayed ctrl_vars onto res_*.
  - res_wen is the valid bit of stage 1.
- No backpressure: both buffers accept and return data every cycle.
- flush (synchronous, any state):
  - next state IDLE, counters reset to 0, pipeline valids cleared;
  - no res_wen after the flush edge, and no done pulse.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous). The state machine returns to IDLE.

## Timing
- Reset values:
  - busy, done, tap_ren, acc_ren, res_wen = 0;
  - all ctrl_vars = 0; res_data = 0.
- start high in cycle 0 (IDLE):
  - tap_ren is high in cycles 1..IMG_W*IMG_H (1..3844 at defaults).
  - res_wen is high in cycles 3..3846.
  - done is high in cycle 3847 only.
  - busy is high in cycles 1..3846.
- Latency from ren issue to the matching wen is exactly 2 cycles. Throughput is 1 pixel per cycle.
- A new start is accepted in the done cycle (IDLE). Back-to-back runs then have a single idle cycle between the last wen and the next ren.
- Holding res_* between writes: res_ctrl_vars and res_data hold their last values when res_wen=0. Only res_wen qualifies them.

## Test plan
- Reset: assert rst_n mid-run at an arbitrary phase -> all outputs 0 in the same cycle. After release, the block stays in IDLE until start.
- Uniform input: all taps=1, acc=0 -> 3844 writes, each res_data=16. wen is contiguous in cycles 3..3846, and done=1 in cycle 3847 only.
- Weight check: taps t0..t8 = 1..9, acc=5 -> res_data=85 (80+5) at every write.
- Overflow: taps all 0x1000, acc=0x0003 -> res_data=0x0003 (0x10000 wraps).
- Sequencing:
  - ren ctrl_vars #1={0,0,0}, #62={0,0,61}, #63={0,1,0}, #3844={0,61,61};
  - each res_ctrl_vars equals the ren value issued 2 cycles earlier;
  - start pulsed during RUN has no effect.
- Flush: flush at cycle 100 of a run -> no res_wen from cycle 101 on, no done, busy=0. A following start restarts at {0,0,0}.
